mr_wb_arb: RTL and testbench

- Two-master to one-slave pipelined Wishbone arbiter.
- Shares the single memory port between the instruction fetch unit (master I, read-only) and the load/store unit (master D).
- Sits between the core and the memory/interconnect.
- Grant is locked for the whole bus cycle (master CYC held) and released with a one-cycle turnaround, so acks are never delivered to the wrong master.

---
 rtl/mr_wb_arb.sv | 166 ++++++++++++++++
 tb/tb_mr_wb_arb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mr_wb_arb.sv
// Two-master (fetch, LSU) to one-slave pipelined Wishbone arbiter.
// Grant is held for the whole master bus cycle, then one idle turnaround cycle.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_GRAN
`define XLEN_GRAN 2
`endif

module mr_wb_arb #(
    parameter int ARB_MODE = 0,
    parameter int MAX_OUT  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [`XLEN-`XLEN_GRAN-1:0]    i_adr_i,
    input  logic                           i_stb_i,
    input  logic                           i_cyc_i,
    output logic [`XLEN-1:0]               i_dat_o,
    output logic                           i_ack_o,
    output logic                           i_err_o,
    output logic                           i_stall_o,
    input  logic [`XLEN-`XLEN_GRAN-1:0]    d_adr_i,
    input  logic [`XLEN-1:0]               d_dat_i,
    input  logic                           d_we_i,
    input  logic [`XLEN/8-1:0]             d_sel_i,
    input  logic                           d_stb_i,
    input  logic                           d_cyc_i,
    output logic [`XLEN-1:0]               d_dat_o,
    output logic                           d_ack_o,
    output logic                           d_err_o,
    output logic                           d_stall_o,
    output logic [`XLEN-`XLEN_GRAN-1:0]    adr_o,
    output logic [`XLEN-1:0]               dat_o,
    output logic                           we_o,
    output logic [`XLEN/8-1:0]             sel_o,
    output logic                           stb_o,
    output logic                           cyc_o,
    input  logic [`XLEN-1:0]               dat_i,
    input  logic                           ack_i,
    input  logic                           err_i,
    input  logic                           stall_i,
    output logic [1:0]                     gnt_o
);

    localparam logic [3:0] MAXC = 4'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, TURN} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_d;
    logic [3:0] out_cnt;
    logic [3:0] cnt_nxt;
    logic       full;
    logic       acc;
    logic       done;
    logic       granted;

    assign full    = (out_cnt >= MAXC);
    assign granted = (state == GNT_I) || (state == GNT_D);
    assign acc     = stb_o & ~stall_i;
    assign done    = i_ack_o | i_err_o | d_ack_o | d_err_o;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_cyc_i && d_cyc_i) begin
                    if (ARB_MODE == 0 || !last_d)
                        state_nxt = GNT_D;
                    else
                        state_nxt = GNT_I;
                end else if (d_cyc_i) begin
                    state_nxt = GNT_D;
                end else if (i_cyc_i) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I:   if (!i_cyc_i) state_nxt = TURN;
            GNT_D:   if (!d_cyc_i) state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced to their idle values while reset is held.
    always_comb begin
        adr_o     = '0;
        dat_o     = '0;
        we_o      = 1'b0;
        sel_o     = '0;
        stb_o     = 1'b0;
        cyc_o     = 1'b0;
        i_ack_o   = 1'b0;
        i_err_o   = 1'b0;
        i_stall_o = 1'b1;
        d_ack_o   = 1'b0;
        d_err_o   = 1'b0;
        d_stall_o = 1'b1;
        gnt_o     = 2'b00;
        if (!rst) begin
            unique case (state)
                GNT_I: begin
                    adr_o     = i_adr_i;
                    sel_o     = '1;
                    cyc_o     = i_cyc_i;
                    stb_o     = i_stb_i & i_cyc_i & ~full;
                    i_stall_o = stall_i | full;
                    i_ack_o   = ack_i;
                    i_err_o   = err_i;
                    gnt_o     = 2'b01;
                end
                GNT_D: begin
                    adr_o     = d_adr_i;
                    dat_o     = d_dat_i;
                    we_o      = d_we_i;
                    sel_o     = d_sel_i;
                    cyc_o     = d_cyc_i;
                    stb_o     = d_stb_i & d_cyc_i & ~full;
                    d_stall_o = stall_i | full;
                    d_ack_o   = ack_i;
                    d_err_o   = err_i;
                    gnt_o     = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign i_dat_o = rst ? '0 : dat_i;
    assign d_dat_o = rst ? '0 : dat_i;

    // Release aborts anything in flight, so the count restarts at zero.
    always_comb begin
        cnt_nxt = '0;
        if (granted && state_nxt == state) begin
            cnt_nxt = out_cnt;
            if (acc && !done)
                cnt_nxt = out_cnt + 4'd1;
            else if (!acc && done && out_cnt != 4'd0)
                cnt_nxt = out_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            out_cnt <= '0;
        end else begin
            state   <= state_nxt;
            out_cnt <= cnt_nxt;
            if (state == IDLE && state_nxt == GNT_D)
                last_d <= 1'b1;
            else if (state == IDLE && state_nxt == GNT_I)
                last_d <= 1'b0;
        end
    end

    a_no_stray_ack: assert property (
        @(posedge clk) disable iff (rst)
        (granted && done && !acc) |-> (out_cnt != 4'd0)
    );

endmodule

// File: tb/tb_mr_wb_arb.sv
// Directed bench for mr_wb_arb: fixed-priority/MAX_OUT=2 instance and a
// round-robin instance, hand-computed expected values.
`timescale 1ns/1ps

module tb_mr_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] i_adr_i;
    logic        i_stb_i, i_cyc_i;
    logic [31:0] i_dat_o;
    logic        i_ack_o, i_err_o, i_stall_o;
    logic [29:0] d_adr_i;
    logic [31:0] d_dat_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic        d_stb_i, d_cyc_i;
    logic [31:0] d_dat_o;
    logic        d_ack_o, d_err_o, d_stall_o;
    logic [29:0] adr_o;
    logic [31:0] dat_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        stb_o, cyc_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i, stall_i;
    logic [1:0]  gnt_o;

    logic        r_i_stb, r_i_cyc, r_d_stb, r_d_cyc, r_ack, r_err;
    logic [31:0] r_i_dat, r_d_dat, r_dat_o;
    logic        r_i_ack, r_i_err, r_i_stall;
    logic        r_d_ack, r_d_err, r_d_stall;
    logic [29:0] r_adr_o;
    logic        r_we_o, r_stb_o, r_cyc_o;
    logic [3:0]  r_sel_o;
    logic [1:0]  r_gnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mr_wb_arb #(.ARB_MODE(0), .MAX_OUT(2)) dut0 (
        .clk(clk), .rst(rst),
        .i_adr_i(i_adr_i), .i_stb_i(i_stb_i), .i_cyc_i(i_cyc_i),
        .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
        .i_stall_o(i_stall_o),
        .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_we_i(d_we_i),
        .d_sel_i(d_sel_i), .d_stb_i(d_stb_i), .d_cyc_i(d_cyc_i),
        .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
        .d_stall_o(d_stall_o),
        .adr_o(adr_o), .dat_o(dat_o), .we_o(we_o), .sel_o(sel_o),
        .stb_o(stb_o), .cyc_o(cyc_o), .dat_i(dat_i), .ack_i(ack_i),
        .err_i(err_i), .stall_i(stall_i), .gnt_o(gnt_o)
    );

    mr_wb_arb #(.ARB_MODE(1), .MAX_OUT(4)) dut1 (
        .clk(clk), .rst(rst),
        .i_adr_i(i_adr_i), .i_stb_i(r_i_stb), .i_cyc_i(r_i_cyc),
        .i_dat_o(r_i_dat), .i_ack_o(r_i_ack), .i_err_o(r_i_err),
        .i_stall_o(r_i_stall),
        .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_we_i(d_we_i),
        .d_sel_i(d_sel_i), .d_stb_i(r_d_stb), .d_cyc_i(r_d_cyc),
        .d_dat_o(r_d_dat), .d_ack_o(r_d_ack), .d_err_o(r_d_err),
        .d_stall_o(r_d_stall),
        .adr_o(r_adr_o), .dat_o(r_dat_o), .we_o(r_we_o), .sel_o(r_sel_o),
        .stb_o(r_stb_o), .cyc_o(r_cyc_o), .dat_i(dat_i), .ack_i(r_ack),
        .err_i(r_err), .stall_i(stall_i), .gnt_o(r_gnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_d;

    initial begin
        rst = 1'b1;
        i_adr_i = '0; i_stb_i = 0; i_cyc_i = 0;
        d_adr_i = '0; d_dat_i = '0; d_we_i = 0; d_sel_i = '0;
        d_stb_i = 0; d_cyc_i = 0;
        dat_i = '0; ack_i = 0; err_i = 0; stall_i = 0;
        r_i_stb = 0; r_i_cyc = 0; r_d_stb = 0; r_d_cyc = 0;
        r_ack = 0; r_err = 0;

        // reset values, stray ack gated
        step(); step();
        ack_i = 1'b1;
        #1;
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_istall", i_stall_o, 1);
        chk("rst_dstall", d_stall_o, 1);
        chk("rst_iack", i_ack_o, 0);
        ack_i = 1'b0;

        // I alone, one read
        step();
        rst = 1'b0;
        i_cyc_i = 1; i_stb_i = 1; i_adr_i = 30'h40;
        #1;
        chk("t1_idle_gnt", gnt_o, 2'b00);
        chk("t1_idle_stb", stb_o, 0);
        step();
        chk("t1_gnt", gnt_o, 2'b01);
        chk("t1_stb", stb_o, 1);
        chk("t1_adr", adr_o, 30'h40);
        chk("t1_sel", sel_o, 4'hf);
        chk("t1_we", we_o, 0);
        chk("t1_istall", i_stall_o, 0);
        chk("t1_dstall", d_stall_o, 1);
        step();
        i_stb_i = 0; ack_i = 1; dat_i = 32'h1234_5678;
        #1;
        chk("t1_iack", i_ack_o, 1);
        chk("t1_dack", d_ack_o, 0);
        chk("t1_idat", i_dat_o, 32'h1234_5678);
        chk("t1_ddat", d_dat_o, 32'h1234_5678);
        chk("t1_dstall2", d_stall_o, 1);
        step();
        ack_i = 0; i_cyc_i = 0;
        #1;
        chk("t1_rel_cyc", cyc_o, 0);
        chk("t1_rel_gnt", gnt_o, 2'b01);
        step();
        chk("t1_turn_gnt", gnt_o, 2'b00);
        chk("t1_turn_istall", i_stall_o, 1);
        step();
        chk("t1_idle2", gnt_o, 2'b00);

        // both request, fixed priority
        i_cyc_i = 1; i_stb_i = 1;
        d_cyc_i = 1; d_stb_i = 1; d_adr_i = 30'h80; d_sel_i = 4'hf;
        step();
        chk("t2_gnt_d", gnt_o, 2'b10);
        chk("t2_istall", i_stall_o, 1);
        chk("t2_dstall", d_stall_o, 0);
        chk("t2_adr", adr_o, 30'h80);
        step();
        d_stb_i = 0; ack_i = 1;
        #1;
        chk("t2_dack", d_ack_o, 1);
        chk("t2_iack", i_ack_o, 0);
        step();
        ack_i = 0; d_cyc_i = 0;
        #1;
        chk("t2_hold", gnt_o, 2'b10);
        step();
        chk("t2_turn", gnt_o, 2'b00);
        chk("t2_turn_cyc", cyc_o, 0);
        step();
        chk("t2_idle", gnt_o, 2'b00);
        step();
        chk("t2_gnt_i", gnt_o, 2'b01);
        chk("t2_i_adr", adr_o, 30'h40);
        step();
        i_cyc_i = 0; i_stb_i = 0;
        step();
        step();

        // MAX_OUT=2 limit
        d_cyc_i = 1; d_stb_i = 1;
        step();
        chk("t4_s1_stb", stb_o, 1);
        chk("t4_s1_stall", d_stall_o, 0);
        step();
        chk("t4_s2_stb", stb_o, 1);
        chk("t4_s2_stall", d_stall_o, 0);
        step();
        ack_i = 1;
        #1;
        chk("t4_full_stb", stb_o, 0);
        chk("t4_full_stall", d_stall_o, 1);
        chk("t4_ack", d_ack_o, 1);
        step();
        ack_i = 0;
        #1;
        chk("t4_s3_stb", stb_o, 1);
        chk("t4_s3_stall", d_stall_o, 0);
        step();
        d_stb_i = 0; ack_i = 1;
        #1;
        chk("t4_full2", d_stall_o, 1);
        step();
        step();
        ack_i = 0; d_cyc_i = 0;
        step();
        step();

        // D write with slave error
        d_cyc_i = 1; d_stb_i = 1; d_we_i = 1; d_sel_i = 4'b0011;
        d_dat_i = 32'hDEAD_BEEF; d_adr_i = 30'h123;
        i_cyc_i = 1; i_stb_i = 1;
        step();
        chk("t5_we", we_o, 1);
        chk("t5_sel", sel_o, 4'b0011);
        chk("t5_dat", dat_o, 32'hDEAD_BEEF);
        chk("t5_adr", adr_o, 30'h123);
        step();
        d_stb_i = 0; err_i = 1;
        #1;
        chk("t5_derr", d_err_o, 1);
        chk("t5_ierr", i_err_o, 0);
        chk("t5_dack", d_ack_o, 0);
        step();
        err_i = 0;
        #1;
        chk("t5_held", gnt_o, 2'b10);
        chk("t5_held_cyc", cyc_o, 1);
        i_cyc_i = 0; i_stb_i = 0;
        step();
        d_cyc_i = 0; d_we_i = 0;
        step();
        step();

        // abort with one outstanding, stray ack in TURN
        d_cyc_i = 1; d_stb_i = 1; d_sel_i = 4'hf;
        step();
        chk("t6_acc", stb_o, 1);
        step();
        d_cyc_i = 0; d_stb_i = 0;
        step();
        ack_i = 1;
        #1;
        chk("t6_turn_dack", d_ack_o, 0);
        chk("t6_turn_iack", i_ack_o, 0);
        chk("t6_turn_cyc", cyc_o, 0);
        step();
        ack_i = 0;
        d_cyc_i = 1; d_stb_i = 1;
        step();
        chk("t6_re_s1", d_stall_o, 0);
        step();
        chk("t6_re_s2_stall", d_stall_o, 0);
        chk("t6_re_s2_stb", stb_o, 1);
        step();
        d_stb_i = 0; ack_i = 1;
        step();
        step();
        ack_i = 0; d_cyc_i = 0;
        step();
        step();

        // reset in the middle of a fetch grant
        i_cyc_i = 1; i_stb_i = 1; stall_i = 1;
        step();
        chk("t7_gnt", gnt_o, 2'b01);
        step();
        rst = 1;
        #1;
        chk("t7_rst_cyc", cyc_o, 0);
        chk("t7_rst_stall", i_stall_o, 1);
        step();
        rst = 0;
        #1;
        chk("t7_idle_gnt", gnt_o, 2'b00);
        chk("t7_idle_cyc", cyc_o, 0);
        step();
        chk("t7_regnt", gnt_o, 2'b01);
        i_cyc_i = 0; i_stb_i = 0; stall_i = 0;
        step();
        step();

        // round-robin alternation
        exp_d = 1'b1;
        r_i_cyc = 1; r_i_stb = 1; r_d_cyc = 1; r_d_stb = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_gnt", r_gnt, exp_d ? 2'b10 : 2'b01);
            chk("rr_lose_stall", exp_d ? r_i_stall : r_d_stall, 1);
            chk("rr_stb", r_stb_o, 1);
            step();
            if (exp_d) r_d_stb = 0; else r_i_stb = 0;
            r_ack = 1;
            #1;
            chk("rr_ack", exp_d ? r_d_ack : r_i_ack, 1);
            chk("rr_lose_ack", exp_d ? r_i_ack : r_d_ack, 0);
            step();
            r_ack = 0;
            if (exp_d) r_d_cyc = 0; else r_i_cyc = 0;
            step();
            r_i_cyc = 1; r_i_stb = 1; r_d_cyc = 1; r_d_stb = 1;
            #1;
            chk("rr_turn", r_gnt, 2'b00);
            step();
            chk("rr_idle", r_gnt, 2'b00);
            exp_d = ~exp_d;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
